// File: rtl/inst_sequencer.sv
// Instruction sequencer: walks a program held in an instruction BRAM and
// hands each word to the DSP execution controller over an en/valid
// handshake. Reports completion, retired count and a watchdog timeout.
module inst_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_inst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [31:0]       imem_rdata,
  output logic              ctrl_en,
  output logic [31:0]       ctrl_inst,
  input  logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] retired
);

  // Watchdog must be able to hold TIMEOUT itself: an instruction accepted on
  // the last allowed ISSUE cycle moves into RELEASE with the count at TIMEOUT.
  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [1:0]      LAT_LOAD = 2'(RD_LAT - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ZERO  = {WD_W{1'b0}};
  localparam logic [WD_W-1:0] WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] RET_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_ISSUE   = 3'd3,
    S_RELEASE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [1:0]        lat_q;
  logic [WD_W-1:0]   wd_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              imem_en_q;
  logic              ctrl_en_q;
  logic [31:0]       ctrl_inst_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] retired_q;

  logic [ADDR_W-1:0] retired_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] remaining_d;
  logic [WD_W-1:0]   wd_d;
  logic              wd_expired;
  logic              more_d;

  // Next-value helpers: saturating retire count, wrapping pc, watchdog step.
  always_comb begin
    retired_d   = retired_q;
    pc_d        = pc_q + A_ONE;
    remaining_d = remaining_q - A_ONE;
    wd_d        = wd_q + WD_ONE;
    wd_expired  = (wd_q >= WD_LAST);
    more_d      = (remaining_q != A_ZERO);
    if (retired_q != RET_MAX) begin
      retired_d = retired_q + A_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= A_ZERO;
      remaining_q <= A_ZERO;
      lat_q       <= 2'd0;
      wd_q        <= WD_ZERO;
      imem_addr_q <= A_ZERO;
      imem_en_q   <= 1'b0;
      ctrl_en_q   <= 1'b0;
      ctrl_inst_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      retired_q   <= A_ZERO;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ctrl_inst_q <= 32'd0;
          ctrl_en_q   <= 1'b0;
          imem_en_q   <= 1'b0;
          imem_addr_q <= A_ZERO;
          if (start) begin
            pc_q        <= base_addr;
            remaining_q <= num_inst;
            retired_q   <= A_ZERO;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (num_inst == A_ZERO) begin
              state_q <= S_FINISH;
            end else begin
              imem_en_q   <= 1'b1;
              imem_addr_q <= base_addr;
              state_q     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          // Read request is on the bus for this single cycle only.
          imem_en_q   <= 1'b0;
          imem_addr_q <= A_ZERO;
          lat_q       <= LAT_LOAD;
          state_q     <= S_WAIT_RD;
        end

        S_WAIT_RD: begin
          if (lat_q == 2'd0) begin
            ctrl_inst_q <= imem_rdata;
            ctrl_en_q   <= 1'b1;
            wd_q        <= WD_ZERO;
            state_q     <= S_ISSUE;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end

        S_ISSUE: begin
          // A valid already present on entry is accepted on the first cycle.
          if (ctrl_valid) begin
            ctrl_en_q   <= 1'b0;
            retired_q   <= retired_d;
            pc_q        <= pc_d;
            remaining_q <= remaining_d;
            wd_q        <= wd_d;
            state_q     <= S_RELEASE;
          end else if (wd_expired) begin
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            ctrl_en_q   <= 1'b0;
            ctrl_inst_q <= 32'd0;
            state_q     <= S_IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end

        S_RELEASE: begin
          // Wait for the controller to drop valid before the next fetch.
          if (!ctrl_valid) begin
            if (more_d) begin
              imem_en_q   <= 1'b1;
              imem_addr_q <= pc_q;
              state_q     <= S_FETCH;
            end else begin
              state_q <= S_FINISH;
            end
          end else if (wd_expired) begin
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            ctrl_en_q   <= 1'b0;
            ctrl_inst_q <= 32'd0;
            state_q     <= S_IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end

        S_FINISH: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          ctrl_inst_q <= 32'd0;
          state_q     <= S_IDLE;
        end

        default: begin
          imem_en_q   <= 1'b0;
          imem_addr_q <= A_ZERO;
          ctrl_en_q   <= 1'b0;
          ctrl_inst_q <= 32'd0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr = imem_addr_q;
  assign imem_en   = imem_en_q;
  assign ctrl_en   = ctrl_en_q;
  assign ctrl_inst = ctrl_inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: two instances (RD_LAT 1 and 3) with a BRAM model
// that only presents data on the exact cycle it is due, and a controller
// model whose valid latency is set per instruction.
module tb_inst_sequencer;

  localparam int AW = 10;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst_s, start_s, stuck_s;
  logic [1:0][AW-1:0] base_s, num_s, imem_addr_s, retired_s;
  logic [1:0]         imem_en_s, ctrl_en_s, busy_s, done_s, error_s;
  logic [1:0][31:0]   ctrl_inst_s;
  logic [31:0]        mem [1024];
  int                 dly [2][64];
  int                 n_checks = 0;
  int                 n_err = 0;
  string              cur_name = "init";

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] stg [3];
    logic [31:0] rdata;
    logic        vld = 1'b0;
    logic        pen = 1'b0;
    int          ecnt = 0;
    int          idx = 0;

    assign rdata = stg[LAT-1];

    inst_sequencer #(.ADDR_W(AW), .RD_LAT(LAT), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst_s[g]), .start(start_s[g]),
      .base_addr(base_s[g]), .num_inst(num_s[g]),
      .imem_addr(imem_addr_s[g]), .imem_en(imem_en_s[g]), .imem_rdata(rdata),
      .ctrl_en(ctrl_en_s[g]), .ctrl_inst(ctrl_inst_s[g]), .ctrl_valid(vld),
      .busy(busy_s[g]), .done(done_s[g]), .error(error_s[g]),
      .retired(retired_s[g]));

    // BRAM model: garbage unless read data is exactly LAT cycles after imem_en.
    always @(posedge clk) begin
      stg[0] <= imem_en_s[g] ? mem[imem_addr_s[g]] : 32'hDEAD_BEEF;
      stg[1] <= stg[0];
      stg[2] <= stg[1];
    end

    // Controller model: valid rises after en was seen high dly[idx] times.
    always @(posedge clk) begin
      if (start_s[g] && !busy_s[g]) idx <= 0;
      else if (pen && !ctrl_en_s[g]) idx <= idx + 1;
      pen <= ctrl_en_s[g];
      if (stuck_s[g]) begin
        vld <= 1'b1;
      end else if (!ctrl_en_s[g]) begin
        ecnt <= 0;
        vld  <= 1'b0;
      end else begin
        ecnt <= ecnt + 1;
        if (ecnt + 1 >= dly[g][idx & 63]) vld <= 1'b1;
      end
    end
  end

  task automatic chk(input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_name, what, obs, exp);
    end
  endtask

  // Runs one program on instance d and checks it against a cycle-budget model.
  task automatic run_prog(input int d, input string name, input int base, input int n,
                          input bit stuck, input int inj_k);
    int          lat, sum, exp_k, exp_ret, end_k, done_cnt, unstable, mism, budget;
    bit          exp_to;
    bit          prev_en;
    logic [31:0] prev_inst;
    int          exp_addr[$];
    logic [31:0] exp_inst[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0] got_inst[$];
    cur_name = $sformatf("%s/d%0d", name, d);
    lat = (d == 0) ? 1 : 3;
    sum = 0; exp_ret = 0; exp_to = 1'b0;
    for (int i = 0; i < n; i++) begin
      int a, dd;
      a  = (base + i) % 1024;
      dd = dly[d][i & 63];
      exp_addr.push_back(a);
      exp_inst.push_back(mem[a]);
      if (stuck) begin
        exp_ret++;
        exp_to = 1'b1;
        break;
      end
      if (dd + 1 < TO) exp_ret++;
      if (dd + 2 >= TO) begin
        exp_to = 1'b1;
        break;
      end
      sum += lat + dd + 4;
    end
    exp_k  = exp_to ? (2 + sum + lat + TO) : (2 + sum);
    budget = exp_k + 40;

    stuck_s[d] = stuck;
    @(negedge clk);
    base_s[d] = AW'(base); num_s[d] = AW'(n); start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    end_k = 0; done_cnt = 0; unstable = 0; prev_en = 1'b0; prev_inst = 32'd0;
    for (int k = 1; k <= budget; k++) begin
      if (k == 1) begin
        chk("error_clr", error_s[d], 1'b0);
        chk("busy_set", busy_s[d], 1'b1);
      end
      if (imem_en_s[d]) got_addr.push_back(imem_addr_s[d]);
      if (ctrl_en_s[d] && !prev_en) got_inst.push_back(ctrl_inst_s[d]);
      if (ctrl_en_s[d] && prev_en && ctrl_inst_s[d] !== prev_inst) unstable++;
      if (done_s[d]) done_cnt++;
      prev_en = ctrl_en_s[d]; prev_inst = ctrl_inst_s[d];
      if (!busy_s[d]) begin
        end_k = k;
        break;
      end
      if (k == inj_k) begin
        start_s[d] = 1'b1; base_s[d] = AW'(5); num_s[d] = AW'(7);
      end else begin
        start_s[d] = 1'b0;
      end
      @(negedge clk);
    end
    start_s[d] = 1'b0;

    chk("end_cycle", end_k, exp_k);
    chk("done_at_end", done_s[d], !exp_to);
    chk("done_count", done_cnt, exp_to ? 0 : 1);
    chk("error", error_s[d], exp_to);
    chk("retired", retired_s[d], exp_ret);
    chk("addr_count", got_addr.size(), exp_addr.size());
    mism = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== AW'(exp_addr[i])) mism++;
    chk("addr_seq", mism, 0);
    chk("inst_count", got_inst.size(), exp_inst.size());
    mism = 0;
    for (int i = 0; i < got_inst.size() && i < exp_inst.size(); i++)
      if (got_inst[i] !== exp_inst[i]) mism++;
    chk("inst_seq", mism, 0);
    chk("inst_stable", unstable, 0);
    repeat (2) @(negedge clk);
    chk("done_pulse", done_s[d], 1'b0);
    chk("inst_idle", ctrl_inst_s[d], 32'd0);
    chk("en_idle", ctrl_en_s[d], 1'b0);
    stuck_s[d] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reset during ISSUE of the second instruction, then a clean run.
  task automatic rst_test(input int d);
    bit seen;
    cur_name = $sformatf("rst/d%0d", d);
    for (int i = 100; i < 103; i++) mem[i] = 32'h8000_0000 | 32'($urandom_range(0, 65535));
    dly[d][0] = 1; dly[d][1] = 1000; dly[d][2] = 1;
    base_s[d] = AW'(100); num_s[d] = AW'(3); start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (ctrl_en_s[d] && retired_s[d] == AW'(1)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_issue2", seen, 1'b1);
    repeat (3) @(negedge clk);
    chk("retired_pre", retired_s[d], 1);
    chk("en_pre", ctrl_en_s[d], 1'b1);
    rst_s[d] = 1'b1;
    @(negedge clk);
    chk("en_post", ctrl_en_s[d], 1'b0);
    chk("busy_post", busy_s[d], 1'b0);
    chk("retired_post", retired_s[d], 0);
    chk("inst_post", ctrl_inst_s[d], 32'd0);
    chk("done_post", done_s[d], 1'b0);
    chk("error_post", error_s[d], 1'b0);
    rst_s[d] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) dly[d][i] = 3;
    run_prog(d, "post_rst", 100, 3, 1'b0, 0);
  endtask

  initial begin
    rst_s = 2'b11; start_s = 2'b00; stuck_s = 2'b00; base_s = '0; num_s = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int g = 0; g < 2; g++) for (int i = 0; i < 64; i++) dly[g][i] = 1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur_name = $sformatf("reset/d%0d", d);
      chk("busy", busy_s[d], 1'b0);
      chk("done", done_s[d], 1'b0);
      chk("error", error_s[d], 1'b0);
      chk("retired", retired_s[d], 0);
      chk("ctrl_en", ctrl_en_s[d], 1'b0);
      chk("imem_en", imem_en_s[d], 1'b0);
      chk("ctrl_inst", ctrl_inst_s[d], 32'd0);
      chk("imem_addr", imem_addr_s[d], 0);
    end
    rst_s = 2'b00;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 4; i < 7; i++) mem[i] = 32'h8000_0000 | 32'($urandom_range(0, 65535));
      dly[d][0] = 6; dly[d][1] = 6; dly[d][2] = 6;
      run_prog(d, "three", 4, 3, 1'b0, 0);

      mem[20] = 32'h0000_0000; mem[21] = 32'h8000_0421;
      dly[d][0] = 2; dly[d][1] = 6;
      run_prog(d, "mix", 20, 2, 1'b0, 0);

      run_prog(d, "zero", 0, 0, 1'b0, 0);

      dly[d][0] = 1000; dly[d][1] = 1000;
      run_prog(d, "timeout", 40, 2, 1'b0, 0);

      dly[d][0] = 3;
      run_prog(d, "after_to", 50, 1, 1'b0, 0);

      run_prog(d, "stuck", 60, 2, 1'b1, 0);

      dly[d][0] = 1; dly[d][1] = 2;
      run_prog(d, "wrap", 1023, 2, 1'b0, 3);

      rst_test(d);

      for (int r = 0; r < 6; r++) begin
        int b, n;
        b = $urandom_range(0, 1023);
        n = $urandom_range(1, 6);
        for (int i = 0; i < 64; i++) dly[d][i] = $urandom_range(1, 14);
        run_prog(d, $sformatf("rand%0d", r), b, n, 1'b0, $urandom_range(2, 8));
      end
    end

    for (int i = 0; i < 64; i++) dly[0][i] = 1;
    run_prog(0, "full", 7, 1023, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Upstream neighbour of the DSP execution controller; walks a program stored in an instruction BRAM.
- For each instruction: fetches the word, presents it on ctrl_inst and runs the en/valid handshake with the controller.
- Drops en after completion and advances to the next word until the program length is exhausted.
- Reports completion, instructions retired, and a watchdog timeout error.

Parameters:
- ADDR_W, 10, instruction BRAM address width.
- RD_LAT, 1, instruction BRAM read latency in cycles (1..3).
- TIMEOUT, 64, maximum cycles to wait for ctrl_valid per instruction before abort (>=8).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; begins program when idle.
- base_addr  input  ADDR_W  address of first instruction, sampled on accepted start.
- num_inst  input  ADDR_W  instruction count, sampled on accepted start.
- imem_addr  output  ADDR_W  instruction BRAM read address.
- imem_en  output  1  instruction BRAM read enable.
- imem_rdata  input  32  instruction BRAM read data, valid RD_LAT cycles after imem_en.
- ctrl_en  output  1  enable to execution controller.
- ctrl_inst  output  32  instruction to execution controller; bit31=1 execute, 0 no-op.
- ctrl_valid  input  1  controller completion flag.
- busy  output  1  high from accepted start until done/error pulse.
- done  output  1  one-cycle pulse on normal completion.
- error  output  1  sticky timeout flag; cleared by rst or next accepted start.
- retired  output  ADDR_W  count of instructions completed in current/last run.

Behaviour:
- Reset value of every output: 0, with FSM in IDLE. Reset mid-run aborts immediately; ctrl_en is 0 on the cycle after rst is sampled high.
- States: IDLE, FETCH, WAIT_RD, ISSUE, RELEASE, FINISH.
- IDLE:
  - start=1 captures base_addr into pc, num_inst into remaining, clears retired and error, and sets busy.
  - If num_inst==0 -> FINISH, else -> FETCH.
  - start while busy is ignored.
- FETCH: imem_en=1 and imem_addr=pc for exactly one cycle -> WAIT_RD. Load the latency counter with RD_LAT-1.
- WAIT_RD:
  - Count down. At zero, register imem_rdata into ctrl_inst -> ISSUE.
  - imem_addr and imem_en are 0 outside FETCH.
- ISSUE:
  - ctrl_en=1; ctrl_inst held stable. The controller samples the instruction on the first ISSUE cycle.
  - Watchdog counts cycles in ISSUE.
  - ctrl_valid=1 -> RELEASE with retired+1, pc+1, remaining-1.
  - If the watchdog reaches TIMEOUT without ctrl_valid: set error, ctrl_en=0 -> IDLE, busy=0, no done pulse.
- RELEASE:
  - ctrl_en=0. Wait until ctrl_valid=0 (controller back in its idle state, at least one cycle).
  - Then -> FETCH if remaining!=0, else FINISH.
  - The watchdog also runs here; a timeout behaves as in ISSUE.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Boundary rules:
  - pc wraps modulo 2^ADDR_W (base 1023, two instructions -> addresses 1023, 0).
  - retired saturates at 2^ADDR_W-1.
  - ctrl_valid already high on ISSUE entry is accepted on that cycle.
  - ctrl_inst is cleared to 0 in IDLE.
  - Watchdog resets on each ISSUE entry.
- Per-instruction overhead with RD_LAT=1: FETCH 1 + WAIT_RD 1 + ISSUE n + RELEASE >=1.

Test Plan:
- Program of 3 execute words at base 4; model controller valid 6 cycles after en -> imem_addr 4,5,6 fetched in order; ctrl_en pulses thrice; done one cycle; retired=3; error=0.
- Mix no-op word 0x0000_0000 and execute word 0x8000_0421; controller returns valid after 2 and 6 cycles -> both retired; ctrl_inst matches each word exactly while ctrl_en high.
- start with num_inst=0 -> done pulse 2 cycles after start; no imem_en, no ctrl_en; retired=0.
- Controller never asserts valid, TIMEOUT=16 -> error=1 after 16 ISSUE cycles; ctrl_en drops; busy=0; no done; next start clears error.
- base_addr=1023, num_inst=2 -> fetch addresses 1023 then 0; start pulse while busy ignored.
- rst asserted during ISSUE -> next cycle ctrl_en=0, busy=0, retired=0, state IDLE; subsequent start runs normally; repeat with RD_LAT=3 and check ctrl_inst load timing.
